dmem_wait_responder: RTL and testbench

//  Memory-side responder for the load/store unit's data bus (cs/wr/mask/addr/data_wr -> data_rd).

---
 rtl/dmem_wait_responder.sv | 79 +++++++
 tb/tb_dmem_wait_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_responder.sv
// dmem_wait_responder: byte-maskable word RAM behind a wait-state FSM with a one-cycle ready pulse
module dmem_wait_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        ready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("WAIT_CYCLES must be in 0..15");
        end
        if (DEPTH_WORDS < 2 || (1 << AW) != DEPTH_WORDS || AW > 30) begin : g_bad_depth
            $error("DEPTH_WORDS must be a power of two in 2..2^30");
        end
    endgenerate
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t        state, state_next;
    logic [3:0]    cnt;
    logic          l_wr, r_wr;
    logic [3:0]    l_mask, r_mask;
    logic [31:0]   l_addr, r_addr, l_data, r_data;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          fault, enter_resp;
    // With no wait states RESP is entered straight from IDLE, before the latches are loaded
    assign r_wr   = state == S_IDLE ? wr      : l_wr;
    assign r_mask = state == S_IDLE ? mask    : l_mask;
    assign r_addr = state == S_IDLE ? addr    : l_addr;
    assign r_data = state == S_IDLE ? data_wr : l_data;
    assign idx        = r_addr[AW+1:2];
    assign fault      = (r_addr >> (AW + 2)) != 32'd0;
    assign enter_resp = state_next == S_RESP;
    assign ready      = state == S_RESP;
    always_comb begin
        state_next = state == S_IDLE ? (cs ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE) :
                     state == S_WAIT ? (cnt == 4'd0 ? S_RESP : S_WAIT) : S_IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            err     <= 1'b0;
            data_rd <= '0;
            l_wr    <= 1'b0;
            l_mask  <= '0;
            l_addr  <= '0;
            l_data  <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && cs) begin
                l_wr   <= wr;
                l_mask <= mask;
                l_addr <= addr;
                l_data <= data_wr;
                cnt    <= 4'(WAIT_CYCLES - 1);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            err <= enter_resp & fault;
            if (enter_resp && !r_wr) data_rd <= fault ? '0 : mem[idx];
        end
    end
    // RAM is not reset; holding rst low blocks any commit so an aborted store is dropped
    always_ff @(posedge clk) begin
        if (rst && enter_resp && r_wr && !fault)
            for (int i = 0; i < 4; i++)
                if (r_mask[i]) mem[idx][8*i +: 8] <= r_data[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb_dmem_wait_responder: directed vector table plus hand sequences for aborts, latching and zero-wait streaming
module tb_dmem_wait_responder;
    logic        clk = 1'b0, rst = 1'b0;
    logic        cs = 1'b0, wr = 1'b0;
    logic [3:0]  mask = '0;
    logic [31:0] addr = '0, data_wr = '0, data_rd;
    logic        ready, err;
    logic        cs0 = 1'b0, wr0 = 1'b0;
    logic [3:0]  mask0 = '0;
    logic [31:0] addr0 = '0, data_wr0 = '0, data_rd0;
    logic        ready0, err0;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    dmem_wait_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .cs(cs), .wr(wr), .mask(mask), .addr(addr),
        .data_wr(data_wr), .data_rd(data_rd), .ready(ready), .err(err)
    );
    dmem_wait_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .cs(cs0), .wr(wr0), .mask(mask0), .addr(addr0),
        .data_wr(data_wr0), .data_rd(data_rd0), .ready(ready0), .err(err0)
    );

    typedef struct {
        logic        w;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        e;
    } vec_t;
    vec_t vecs[18];
    vec_t vz[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Starts in an IDLE cycle at a negedge; returns one negedge after the ready cycle
    task automatic access(input logic w, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic e);
        cs = 1'b1; wr = w; mask = m; addr = a; data_wr = d;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ready && lat < 20);
        rd = data_rd;
        e  = err;
        cs = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e, seen;
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 4'h2, 32'h0000_0010, 32'h0000AA00, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hDEADAAEF, 1'b0};
        vecs[4]  = '{1'b1, 4'hF, 32'h0000_0014, 32'h12345678, 32'hDEADAAEF, 1'b0};
        vecs[5]  = '{1'b1, 4'h0, 32'h0000_0014, 32'hFFFFFFFF, 32'hDEADAAEF, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 32'h0000_0014, 32'h0,        32'h12345678, 1'b0};
        vecs[7]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h11223344, 32'h12345678, 1'b0};
        vecs[8]  = '{1'b1, 4'hF, 32'h0000_1000, 32'h99999999, 32'h12345678, 1'b1};
        vecs[9]  = '{1'b0, 4'h0, 32'h0000_1000, 32'h0,        32'h00000000, 1'b1};
        vecs[10] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        32'h11223344, 1'b0};
        vecs[11] = '{1'b0, 4'h0, 32'h0000_0013, 32'h0,        32'hDEADAAEF, 1'b0};
        vecs[12] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'hCAFEF00D, 32'hDEADAAEF, 1'b0};
        vecs[13] = '{1'b1, 4'h9, 32'h0000_0FFC, 32'hA5000077, 32'hDEADAAEF, 1'b0};
        vecs[14] = '{1'b0, 4'h0, 32'h0000_0FFF, 32'h0,        32'hA5FEF077, 1'b0};
        vecs[15] = '{1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,        32'h00000000, 1'b1};
        vecs[16] = '{1'b1, 4'hF, 32'h8000_0000, 32'h55555555, 32'h00000000, 1'b1};
        vecs[17] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,        32'h11223344, 1'b0};
        vz[0] = '{1'b1, 4'hF, 32'h3C, 32'h01020304, 32'h00000000, 1'b0};
        vz[1] = '{1'b0, 4'h0, 32'h3C, 32'h0,        32'h01020304, 1'b0};
        vz[2] = '{1'b1, 4'hF, 32'h3C, 32'hA0B0C0D0, 32'h01020304, 1'b0};
        vz[3] = '{1'b0, 4'h0, 32'h3C, 32'h0,        32'hA0B0C0D0, 1'b0};
        vz[4] = '{1'b0, 4'h0, 32'h40, 32'h0,        32'h00000000, 1'b1};

        repeat (2) @(negedge clk);
        chk("reset ready", ready, 0);
        chk("reset err", err, 0);
        chk("reset data_rd", data_rd, 0);
        chk("reset ready0", ready0, 0);
        chk("reset data_rd0", data_rd0, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            access(vecs[i].w, vecs[i].m, vecs[i].a, vecs[i].d, lat, rd, e);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'd3);
            chk($sformatf("v%0d data_rd", i), rd, vecs[i].rd);
            chk($sformatf("v%0d err", i), e, vecs[i].e);
            chk($sformatf("v%0d ready drop", i), ready, 0);
            chk($sformatf("v%0d err drop", i), err, 0);
        end

        // reset pulsed while a store waits: the store must vanish without a response
        access(1'b1, 4'hF, 32'h20, 32'hAAAA5555, lat, rd, e);
        cs = 1'b1; wr = 1'b1; mask = 4'hF; addr = 32'h20; data_wr = 32'h0BADF00D;
        @(negedge clk);
        chk("abort in wait", ready, 0);
        cs = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); seen |= ready; end
        chk("abort no ready", seen, 0);
        access(1'b0, 4'h0, 32'h20, 32'h0, lat, rd, e);
        chk("abort old data", rd, 32'hAAAA5555);

        // reset asserted inside the ready cycle drops ready and clears outputs at once
        cs = 1'b1; wr = 1'b0; mask = 4'h0; addr = 32'h10; data_wr = 32'h0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ready && lat < 20);
        chk("resp pre-reset ready", ready, 1);
        chk("resp pre-reset data", data_rd, 32'hDEADAAEF);
        cs = 1'b0; rst = 1'b0;
        #1;
        chk("resp async ready", ready, 0);
        chk("resp async data_rd", data_rd, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // bus changes during WAIT must not affect the accepted store
        cs = 1'b1; wr = 1'b1; mask = 4'hF; addr = 32'h30; data_wr = 32'h13572468;
        @(negedge clk);
        wr = 1'b0; mask = 4'h0; addr = 32'h34; data_wr = 32'hFFFFFFFF;
        lat = 1;
        while (!ready && lat < 20) begin @(negedge clk); lat++; end
        chk("latched latency", 32'(lat), 32'd3);
        chk("latched err", err, 0);
        chk("latched store keeps data_rd", data_rd, 0);
        cs = 1'b0;
        @(negedge clk);
        access(1'b0, 4'h0, 32'h30, 32'h0, lat, rd, e);
        chk("latched readback", rd, 32'h13572468);

        // zero wait states with cs held: ready every second cycle, RAW on the next access
        cs0 = 1'b1; wr0 = vz[0].w; mask0 = vz[0].m; addr0 = vz[0].a; data_wr0 = vz[0].d;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("w0 ready k%0d", k), ready0, 32'(k % 2));
            if (k % 2 == 1) begin
                int j;
                j = (k - 1) / 2;
                chk($sformatf("w0 data_rd r%0d", j), data_rd0, vz[j].rd);
                chk($sformatf("w0 err r%0d", j), err0, vz[j].e);
                if (j < 4) begin
                    wr0 = vz[j+1].w; mask0 = vz[j+1].m; addr0 = vz[j+1].a; data_wr0 = vz[j+1].d;
                end else begin
                    cs0 = 1'b0;
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
